// File: rtl/bram_stream_if.sv
// Valid/ready word stream with packet markers, carrying block-RAM read-out data.
interface bram_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sop;
    logic                  out_eop;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output out_ready
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Walks a contiguous block-RAM address range and emits one word per beat on a
// valid/ready stream with sop/eop markers; all outputs registered.
//   state     | meaning
//   ST_IDLE   | waiting for start; zero-length start only pulses done
//   ST_STREAM | reading words and presenting them on the stream
module bram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    bram_stream_if.master         out_if
);
    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [ADDR_WIDTH:0]   remaining_d;
    logic                  first_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_sop_q;
    logic                  out_eop_q;
    logic                  accept;
    logic                  load;

    assign rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
    assign remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
    assign accept      = out_valid_q && out_if.out_ready;
    // Refill the output register whenever it is empty or being drained this cycle.
    assign load        = (remaining_q != '0) && (!out_valid_q || out_if.out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            rd_addr_q   <= start_addr;
                            remaining_q <= length;
                            first_q     <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= ST_STREAM;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                        out_sop_q   <= 1'b0;
                        out_eop_q   <= 1'b0;
                    end else if (accept && out_eop_q) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_sop_q   <= 1'b0;
                        out_eop_q   <= 1'b0;
                    end else if (load) begin
                        out_data_q  <= mem_rdata;
                        out_valid_q <= 1'b1;
                        out_sop_q   <= first_q;
                        first_q     <= 1'b0;
                        out_eop_q   <= (remaining_q == (ADDR_WIDTH + 1)'(1));
                        rd_addr_q   <= rd_addr_d;
                        remaining_q <= remaining_d;
                    end else if (accept) begin
                        out_valid_q <= 1'b0;
                        out_sop_q   <= 1'b0;
                        out_eop_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign mem_raddr        = rd_addr_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_sop   = out_sop_q;
    assign out_if.out_eop   = out_eop_q;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a combinational memory model
// whose word at address i is i[7:0]^8'hA5.
module tb_bram_stream_reader;
    localparam int DW = 8;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    bram_stream_if #(.DATA_WIDTH(DW)) s_if ();

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .start_addr(start_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out_if    (s_if)
    );

    assign mem_rdata = mem_raddr[7:0] ^ 8'hA5;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] bdat[$];
    logic       bsop[$];
    logic       beop[$];
    int         fv_cyc;
    int         dn_cyc;
    int         dn_cnt;
    int         hold_bad;
    logic       vh[0:31];
    logic       bh[0:31];
    logic [AW-1:0] ah1;

    // Issues a start at the current negedge, then samples 31 negedges.
    task automatic run(input logic [AW-1:0] a, input logic [AW:0] len, input logic [31:0] pat,
                       input int abort_cyc, input int restart_cyc);
        logic [7:0] pd;
        logic       ps;
        logic       pe;
        logic       pheld;
        bdat.delete();
        bsop.delete();
        beop.delete();
        fv_cyc   = -1;
        dn_cyc   = -1;
        dn_cnt   = 0;
        hold_bad = 0;
        pheld    = 1'b0;
        pd = '0; ps = 1'b0; pe = 1'b0;
        start = 1'b1;
        start_addr = a;
        length = len;
        s_if.out_ready = pat[0];
        for (int c = 1; c < 32; c++) begin
            @(negedge clk);
            start = (c == restart_cyc);
            if (c == restart_cyc) begin
                start_addr = a + AW'(64);
                length = (AW + 1)'(5);
            end
            abort = (c == abort_cyc);
            s_if.out_ready = pat[c];
            vh[c] = s_if.out_valid;
            bh[c] = busy;
            if (c == 1) ah1 = mem_raddr;
            if (pheld && (c - 1 != abort_cyc) &&
                ({s_if.out_valid, s_if.out_data, s_if.out_sop, s_if.out_eop} !== {1'b1, pd, ps, pe}))
                hold_bad++;
            if (s_if.out_valid && fv_cyc < 0) fv_cyc = c;
            if (s_if.out_valid && s_if.out_ready) begin
                bdat.push_back(s_if.out_data);
                bsop.push_back(s_if.out_sop);
                beop.push_back(s_if.out_eop);
            end
            pheld = s_if.out_valid && !s_if.out_ready;
            pd = s_if.out_data;
            ps = s_if.out_sop;
            pe = s_if.out_eop;
            if (done) begin
                dn_cnt++;
                if (dn_cyc < 0) dn_cyc = c;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] dat,
                               input logic [3:0] sop, input logic [3:0] eop);
        check({tag, "_nbeats"}, bdat.size(), n);
        for (int i = 0; i < n && i < bdat.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), bdat[i], dat[8*(n-1-i) +: 8]);
            check($sformatf("%s_sop%0d", tag, i), bsop[i], sop[i]);
            check($sformatf("%s_eop%0d", tag, i), beop[i], eop[i]);
        end
    endtask

    initial begin
        s_if.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_valid", s_if.out_valid, 0);
        check("rst_raddr", mem_raddr, 0);
        check("rst_data",  s_if.out_data, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // basic 4-word packet, sink always ready
        run(19'h10, 20'd4, 32'hFFFF_FFFF, 0, 0);
        check_beats("t1", 4, 32'hB5B4B7B6, 4'b0001, 4'b1000);
        check("t1_busy_c1",  bh[1], 1);
        check("t1_raddr_c1", ah1, 19'h10);
        check("t1_first_v",  fv_cyc, 2);
        check("t1_done_cyc", dn_cyc, 6);
        check("t1_done_cnt", dn_cnt, 1);
        check("t1_busy_c5",  bh[5], 1);
        check("t1_busy_c6",  bh[6], 0);

        // same packet with ready toggling
        run(19'h10, 20'd4, 32'hFFFF_FEA7, 0, 0);
        check_beats("t2", 4, 32'hB5B4B7B6, 4'b0001, 4'b1000);
        check("t2_hold",     hold_bad, 0);
        check("t2_done_cnt", dn_cnt, 1);

        // address wrap from top of memory
        run(19'h7FFFE, 20'd3, 32'hFFFF_FFFF, 0, 0);
        check_beats("t3", 3, 32'h005B5AA5, 4'b0001, 4'b0100);
        check("t3_done_cnt", dn_cnt, 1);

        // zero length
        run(19'h0, 20'd0, 32'hFFFF_FFFF, 0, 0);
        check("t4_nbeats",   bdat.size(), 0);
        check("t4_first_v",  fv_cyc, -1);
        check("t4_done_cyc", dn_cyc, 1);
        check("t4_done_cnt", dn_cnt, 1);
        check("t4_busy_c1",  bh[1], 0);

        // single word
        run(19'h55, 20'd1, 32'hFFFF_FFFF, 0, 0);
        check_beats("t5", 1, 32'h000000F0, 4'b0001, 4'b0001);
        check("t5_done_cyc", dn_cyc, 3);

        // abort with an unaccepted beat pending
        run(19'h0, 20'd8, 32'h0000_000F, 4, 0);
        check_beats("t6", 2, 32'h0000A5A4, 4'b0001, 4'b0000);
        check("t6_valid_c4", vh[4], 1);
        check("t6_valid_c5", vh[5], 0);
        check("t6_busy_c5",  bh[5], 0);
        check("t6_done_cnt", dn_cnt, 0);

        run(19'h20, 20'd2, 32'hFFFF_FFFF, 0, 0);
        check_beats("t7", 2, 32'h00008584, 4'b0001, 4'b0010);
        check("t7_done_cnt", dn_cnt, 1);

        // asynchronous reset mid-transfer
        start = 1'b1;
        start_addr = 19'h40;
        length = 20'd8;
        s_if.out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t8_pre_valid", s_if.out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t8_busy",  busy, 0);
        check("t8_valid", s_if.out_valid, 0);
        check("t8_sop",   s_if.out_sop, 0);
        check("t8_data",  s_if.out_data, 0);
        check("t8_raddr", mem_raddr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // start pulsed while busy must be ignored
        run(19'h30, 20'd3, 32'hFFFF_FFFF, 0, 3);
        check_beats("t9", 3, 32'h00959497, 4'b0001, 4'b0100);
        check("t9_done_cnt", dn_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
